// File: rtl/pipe_hazard_unit.sv
// Hazard detection, operand forwarding and pipeline control for the q1-q5 core:
// load-use stalls, data-memory wait freezes, redirect flushes and perf counters.
module pipe_hazard_unit #(
    parameter int XLEN        = 32,
    parameter int NRS         = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRS*5-1:0]      rs_q2,
    input  logic [NRS-1:0]        rs_used_q2,
    input  logic [NRS*5-1:0]      rs_q3,
    input  logic [NRS*XLEN-1:0]   op_q3,
    input  logic [4:0]            rd_q3,
    input  logic [4:0]            rd_q4,
    input  logic [4:0]            rd_q5,
    input  logic                  wr_en_q3,
    input  logic                  wr_en_q4,
    input  logic                  wr_en_q5,
    input  logic                  load_q3,
    input  logic                  load_q4,
    input  logic                  mem_req_q3,
    input  logic                  mem_ready,
    input  logic [XLEN-1:0]       result_q4,
    input  logic [XLEN-1:0]       result_q5,
    input  logic                  redirect_q4,
    input  logic                  cnt_clr,
    output logic [NRS*XLEN-1:0]   fwd_op,
    output logic [NRS*2-1:0]      fwd_sel,
    output logic                  stall_fe,
    output logic                  bubble_ex,
    output logic                  freeze,
    output logic                  bubble_wb,
    output logic [2:0]            flush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic                  mem_timeout_err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
    localparam logic [2:0] FLUSH_MASK = 3'((4'd1 << FLUSH_DEPTH) - 4'd1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              load_use;
    logic              redirect_act;
    logic              timeout_hit;

    // q4 may only forward ALU results; load data becomes available from q5
    always_comb begin
        fwd_op  = op_q3;
        fwd_sel = '0;
        for (int i = 0; i < NRS; i++) begin
            if (wr_en_q4 && !load_q4 && rd_q4 != 5'd0 && rd_q4 == rs_q3[i*5 +: 5]) begin
                fwd_op[i*XLEN +: XLEN] = result_q4;
                fwd_sel[i*2 +: 2]      = 2'b01;
            end else if (wr_en_q5 && rd_q5 != 5'd0 && rd_q5 == rs_q3[i*5 +: 5]) begin
                fwd_op[i*XLEN +: XLEN] = result_q5;
                fwd_sel[i*2 +: 2]      = 2'b10;
            end
        end
    end

    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NRS; i++) begin
            if (rs_used_q2[i] && rs_q2[i*5 +: 5] == rd_q3)
                load_use = 1'b1;
        end
        load_use = load_use && load_q3 && wr_en_q3 && rd_q3 != 5'd0;
    end

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        freeze     = 1'b0;
        case (state)
            RUN: begin
                if (mem_req_q3 && !mem_ready) begin
                    freeze     = 1'b1;
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end else begin
                    wait_next = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next = RUN;
                    wait_next  = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt != TIMEOUT_V)
                        wait_next = wait_cnt + 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // freeze outranks redirect, which outranks the load-use stall
    assign timeout_hit  = freeze && (wait_next == TIMEOUT_V);
    assign redirect_act = redirect_q4 && !freeze;
    assign flush        = redirect_act ? FLUSH_MASK : 3'b000;
    assign stall_fe     = load_use && !freeze && !redirect_q4;
    assign bubble_ex    = stall_fe;
    assign bubble_wb    = freeze;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt       <= '0;
            flush_cnt       <= '0;
            mem_timeout_err <= 1'b0;
        end else if (cnt_clr) begin
            stall_cnt       <= '0;
            flush_cnt       <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            if ((stall_fe || freeze) && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            if (redirect_act && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + 1'b1;
            if (timeout_hit)
                mem_timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: vector table for the combinational paths,
// hand-written sequences for memory waits, counters, saturation and reset.
module tb_pipe_hazard_unit;

    localparam int XLEN = 32;
    localparam int NRS  = 3;
    localparam int CNT_W = 4;

    localparam logic [31:0] P0 = 32'h100;
    localparam logic [31:0] P1 = 32'h101;
    localparam logic [31:0] P2 = 32'h102;
    localparam logic [31:0] AA = 32'hAA;
    localparam logic [31:0] BB = 32'hBB;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NRS*5-1:0]    rs_q2, rs_q3;
    logic [NRS-1:0]      rs_used_q2;
    logic [NRS*XLEN-1:0] op_q3;
    logic [4:0]          rd_q3, rd_q4, rd_q5;
    logic                wr_en_q3, wr_en_q4, wr_en_q5;
    logic                load_q3, load_q4, mem_req_q3, mem_ready;
    logic [XLEN-1:0]     result_q4, result_q5;
    logic                redirect_q4, cnt_clr;
    logic [NRS*XLEN-1:0] fwd_op;
    logic [NRS*2-1:0]    fwd_sel;
    logic                stall_fe, bubble_ex, freeze, bubble_wb;
    logic [2:0]          flush;
    logic [CNT_W-1:0]    stall_cnt, flush_cnt;
    logic                mem_timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_unit #(
        .XLEN(XLEN), .NRS(NRS), .FLUSH_DEPTH(2), .CNT_W(CNT_W), .MEM_TIMEOUT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rs_q2(rs_q2), .rs_used_q2(rs_used_q2),
        .rs_q3(rs_q3), .op_q3(op_q3), .rd_q3(rd_q3), .rd_q4(rd_q4), .rd_q5(rd_q5),
        .wr_en_q3(wr_en_q3), .wr_en_q4(wr_en_q4), .wr_en_q5(wr_en_q5),
        .load_q3(load_q3), .load_q4(load_q4), .mem_req_q3(mem_req_q3),
        .mem_ready(mem_ready), .result_q4(result_q4), .result_q5(result_q5),
        .redirect_q4(redirect_q4), .cnt_clr(cnt_clr), .fwd_op(fwd_op),
        .fwd_sel(fwd_sel), .stall_fe(stall_fe), .bubble_ex(bubble_ex),
        .freeze(freeze), .bubble_wb(bubble_wb), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_timeout_err(mem_timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] rs3;
        logic [4:0]  rd4;
        logic        w4;
        logic        l4;
        logic [4:0]  rd5;
        logic        w5;
        logic [14:0] rs2;
        logic [2:0]  used;
        logic [4:0]  rd3;
        logic        l3;
        logic        w3;
        logic        redir;
        logic [95:0] eop;
        logic [5:0]  esel;
        logic        estall;
        logic [2:0]  eflush;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_q2 = '0; rs_used_q2 = '0; rs_q3 = '0;
        rd_q3 = '0; rd_q4 = '0; rd_q5 = '0;
        wr_en_q3 = 0; wr_en_q4 = 0; wr_en_q5 = 0;
        load_q3 = 0; load_q4 = 0; mem_req_q3 = 0; mem_ready = 0;
        redirect_q4 = 0;
    endtask

    task automatic set_load_use();
        load_q3 = 1; wr_en_q3 = 1; rd_q3 = 5'd7;
        rs_q2 = {5'd0, 5'd7, 5'd0}; rs_used_q2 = 3'b010;
    endtask

    task automatic apply(input vec_t v);
        rs_q3 = v.rs3; rd_q4 = v.rd4; wr_en_q4 = v.w4; load_q4 = v.l4;
        rd_q5 = v.rd5; wr_en_q5 = v.w5; rs_q2 = v.rs2; rs_used_q2 = v.used;
        rd_q3 = v.rd3; load_q3 = v.l3; wr_en_q3 = v.w3; redirect_q4 = v.redir;
    endtask

    initial begin
        int fcount;
        op_q3 = {P2, P1, P0};
        result_q4 = AA;
        result_q5 = BB;
        cnt_clr = 0;
        idle();

        vecs[0]  = '{15'd0, 5'd0, 0, 0, 5'd0, 0, 15'd0, 3'b000, 5'd0, 0, 0, 0, {P2, P1, P0}, 6'b000000, 0, 3'b000};
        vecs[1]  = '{{5'd0, 5'd0, 5'd5}, 5'd5, 1, 0, 5'd5, 1, 15'd0, 3'b000, 5'd0, 0, 0, 0, {P2, P1, AA}, 6'b000001, 0, 3'b000};
        vecs[2]  = '{{5'd0, 5'd0, 5'd5}, 5'd5, 0, 0, 5'd5, 1, 15'd0, 3'b000, 5'd0, 0, 0, 0, {P2, P1, BB}, 6'b000010, 0, 3'b000};
        vecs[3]  = '{15'd0, 5'd0, 1, 0, 5'd0, 1, 15'd0, 3'b000, 5'd0, 0, 0, 0, {P2, P1, P0}, 6'b000000, 0, 3'b000};
        vecs[4]  = '{{5'd5, 5'd5, 5'd5}, 5'd5, 1, 1, 5'd5, 1, 15'd0, 3'b000, 5'd0, 0, 0, 0, {BB, BB, BB}, 6'b101010, 0, 3'b000};
        vecs[5]  = '{{5'd9, 5'd6, 5'd5}, 5'd6, 1, 0, 5'd9, 1, 15'd0, 3'b000, 5'd0, 0, 0, 0, {BB, AA, P0}, 6'b100100, 0, 3'b000};
        vecs[6]  = '{15'd0, 5'd0, 0, 0, 5'd0, 0, {5'd0, 5'd7, 5'd0}, 3'b010, 5'd7, 1, 1, 0, {P2, P1, P0}, 6'b000000, 1, 3'b000};
        vecs[7]  = '{15'd0, 5'd0, 0, 0, 5'd0, 0, {5'd0, 5'd7, 5'd0}, 3'b101, 5'd7, 1, 1, 0, {P2, P1, P0}, 6'b000000, 0, 3'b000};
        vecs[8]  = '{15'd0, 5'd0, 0, 0, 5'd0, 0, 15'd0, 3'b010, 5'd0, 1, 1, 0, {P2, P1, P0}, 6'b000000, 0, 3'b000};
        vecs[9]  = '{15'd0, 5'd0, 0, 0, 5'd0, 0, {5'd0, 5'd7, 5'd0}, 3'b010, 5'd7, 0, 1, 0, {P2, P1, P0}, 6'b000000, 0, 3'b000};
        vecs[10] = '{15'd0, 5'd0, 0, 0, 5'd0, 0, {5'd0, 5'd7, 5'd0}, 3'b010, 5'd7, 1, 0, 0, {P2, P1, P0}, 6'b000000, 0, 3'b000};
        vecs[11] = '{15'd0, 5'd0, 0, 0, 5'd0, 0, {5'd0, 5'd7, 5'd0}, 3'b010, 5'd7, 1, 1, 1, {P2, P1, P0}, 6'b000000, 0, 3'b011};
        vecs[12] = '{15'd0, 5'd0, 0, 0, 5'd0, 0, 15'd0, 3'b000, 5'd0, 0, 0, 1, {P2, P1, P0}, 6'b000000, 0, 3'b011};
        vecs[13] = '{15'd0, 5'd0, 0, 0, 5'd0, 0, {5'd7, 5'd0, 5'd0}, 3'b100, 5'd7, 1, 1, 0, {P2, P1, P0}, 6'b000000, 1, 3'b000};

        // reset state
        #2 rst_n = 0;
        #1;
        chk("rst_fwd_sel", 96'(fwd_sel), 96'd0);
        chk("rst_fwd_op", fwd_op, {P2, P1, P0});
        chk("rst_ctrl", 96'({stall_fe, bubble_ex, freeze, bubble_wb, flush}), 96'd0);
        chk("rst_cnt", 96'({stall_cnt, flush_cnt, mem_timeout_err}), 96'd0);
        step();
        step();
        rst_n = 1;

        // combinational table, counters held clear
        cnt_clr = 1;
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d_fwd_op", i), fwd_op, vecs[i].eop);
            chk($sformatf("v%0d_fwd_sel", i), 96'(fwd_sel), 96'(vecs[i].esel));
            chk($sformatf("v%0d_stall_fe", i), 96'(stall_fe), 96'(vecs[i].estall));
            chk($sformatf("v%0d_bubble_ex", i), 96'(bubble_ex), 96'(vecs[i].estall));
            chk($sformatf("v%0d_flush", i), 96'(flush), 96'(vecs[i].eflush));
            chk($sformatf("v%0d_freeze", i), 96'(freeze), 96'd0);
            step();
        end
        chk("clr_wins_stall", 96'(stall_cnt), 96'd0);
        chk("clr_wins_flush", 96'(flush_cnt), 96'd0);
        cnt_clr = 0;
        idle();
        step();

        // single load-use stall
        set_load_use();
        #1 chk("lu_stall", 96'(stall_fe), 96'd1);
        step();
        idle();
        #1;
        chk("lu_stall_drop", 96'(stall_fe), 96'd0);
        chk("lu_stall_cnt", 96'(stall_cnt), 96'd1);

        // 3-cycle memory wait with timeout at 2
        cnt_clr = 1; step(); cnt_clr = 0;
        mem_req_q3 = 1; mem_ready = 0;
        fcount = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (freeze && bubble_wb) fcount++;
            step();
        end
        mem_ready = 1;
        #1 chk("mw_release", 96'(freeze), 96'd0);
        step();
        mem_req_q3 = 0; mem_ready = 0;
        #1;
        chk("mw_freeze_cycles", 96'(fcount), 96'd3);
        chk("mw_stall_cnt", 96'(stall_cnt), 96'd3);
        chk("mw_timeout_err", 96'(mem_timeout_err), 96'd1);
        chk("mw_back_to_run", 96'(freeze), 96'd0);
        step();
        chk("mw_err_sticky", 96'(mem_timeout_err), 96'd1);
        cnt_clr = 1; step(); cnt_clr = 0;
        #1;
        chk("mw_err_cleared", 96'(mem_timeout_err), 96'd0);
        chk("mw_cnt_cleared", 96'(stall_cnt), 96'd0);

        // one-cycle wait stays below the timeout
        mem_req_q3 = 1; mem_ready = 0;
        #1 chk("short_freeze", 96'(freeze), 96'd1);
        step();
        mem_ready = 1;
        #1 chk("short_release", 96'(freeze), 96'd0);
        step();
        idle();
        #1 chk("short_no_err", 96'(mem_timeout_err), 96'd0);

        // request completing in the same cycle
        mem_req_q3 = 1; mem_ready = 1;
        #1 chk("same_cycle_freeze", 96'(freeze), 96'd0);
        step();
        idle();
        #1 chk("same_cycle_no_wait", 96'(freeze), 96'd0);

        // redirect while frozen is held off until the memory completes
        cnt_clr = 1; step(); cnt_clr = 0;
        mem_req_q3 = 1; mem_ready = 0; redirect_q4 = 1; set_load_use();
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("frz_redir_flush%0d", c), 96'(flush), 96'd0);
            chk($sformatf("frz_redir_stall%0d", c), 96'(stall_fe), 96'd0);
            step();
        end
        mem_ready = 1;
        #1 chk("frz_redir_release", 96'(flush), 96'b011);
        step();
        idle();
        #1 chk("frz_redir_flush_cnt", 96'(flush_cnt), 96'd1);

        // saturation at 2^CNT_W-1
        cnt_clr = 1; step(); cnt_clr = 0;
        set_load_use();
        redirect_q4 = 0;
        for (int c = 0; c < 20; c++) step();
        idle();
        #1 chk("stall_sat", 96'(stall_cnt), 96'd15);
        redirect_q4 = 1;
        for (int c = 0; c < 20; c++) step();
        idle();
        #1 chk("flush_sat", 96'(flush_cnt), 96'd15);

        // asynchronous reset in the middle of a wait
        mem_req_q3 = 1; mem_ready = 0;
        step();
        step();
        mem_req_q3 = 0;
        #1;
        chk("pre_rst_freeze", 96'(freeze), 96'd1);
        chk("pre_rst_err", 96'(mem_timeout_err), 96'd1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_freeze", 96'(freeze), 96'd0);
        chk("async_rst_bubble_wb", 96'(bubble_wb), 96'd0);
        chk("async_rst_cnt", 96'({stall_cnt, flush_cnt}), 96'd0);
        chk("async_rst_err", 96'(mem_timeout_err), 96'd0);
        step();
        rst_n = 1;
        step();
        #1 chk("post_rst_run", 96'(freeze), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard-detection, forwarding and pipeline-control unit for the 5-stage (q1–q5) core. It resolves read-after-write hazards on an arbitrary number of operand ports and generates load-use stalls, data-memory wait freezes and branch-redirect flushes, replacing the fixed two-operand forwarding logic. It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

## Interface
- XLEN, 32, datapath width
- NRS, 3, operand ports checked in q3/q2 (rs1, rs2, store data)
- FLUSH_DEPTH, 2, pipeline registers flushed on redirect (1..3: q1q2, q2q3, q3q4)
- CNT_W, 16, performance counter width
- MEM_TIMEOUT, 255, max mem wait cycles before error (≥1)

- clk  in  1  clock; reset is asynchronous and active-low
- rst_n  in  1  async active-low reset
- rs_q2  in  NRS*5  decode-stage source indices
- rs_used_q2  in  NRS  source actually read by decode instr
- rs_q3  in  NRS*5  execute-stage source indices
- op_q3  in  NRS*XLEN  un-forwarded operand values (regfile/imm path)
- rd_q3, rd_q4, rd_q5  in  5 each  destination indices
- wr_en_q3, wr_en_q4, wr_en_q5  in  1 each  reg write enables
- load_q3, load_q4  in  1 each  instr is a load
- mem_req_q3  in  1  data memory access issued
- mem_ready  in  1  data memory completes this cycle
- result_q4, result_q5  in  XLEN each  ALU result (q4), final writeback value (q5)
- redirect_q4  in  1  taken branch/jump in q4
- cnt_clr  in  1  sync clear of counters and error flag
- fwd_op  out  NRS*XLEN  forwarded operands
- fwd_sel  out  NRS*2  per port 00 none, 01 q4, 10 q5
- stall_fe  out  1  hold PC and q1q2
- bubble_ex  out  1  load NOP into q2q3
- freeze  out  1  hold PC, q1q2, q2q3, q3q4
- bubble_wb  out  1  load NOP into q4q5
- flush  out  3  bit0 q1q2, bit1 q2q3, bit2 q3q4
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters
- mem_timeout_err  out  1  sticky

## Operation
- Forwarding, per port i: q4 hit = wr_en_q4 & !load_q4 & rd_q4==rs_q3[i] & rd_q4!=0; q5 hit = wr_en_q5 & rd_q5==rs_q3[i] & rd_q5!=0. Priority q4 > q5 > op_q3. x0 never forwarded. Loads forward only from q5.
- Load-use: load_q3 & wr_en_q3 & rd_q3!=0 & any(rs_used_q2[i] & rs_q2[i]==rd_q3) → stall_fe=1, bubble_ex=1 for that cycle.
- FSM states RUN, MEM_WAIT.
  - RUN → MEM_WAIT when mem_req_q3 & !mem_ready; freeze=1, bubble_wb=1 same cycle.
  - MEM_WAIT: freeze=1, bubble_wb=1 while !mem_ready; wait counter increments; on mem_ready → RUN (freeze deasserted that cycle).
  - Wait counter reaching MEM_TIMEOUT sets mem_timeout_err; stays in MEM_WAIT.
- Priority: freeze > redirect > load-use. While freeze=1: flush=0, stall_fe=0, bubble_ex=0.
- Redirect (redirect_q4 & !freeze): flush[k]=1 for k<FLUSH_DEPTH; load-use stall suppressed.
- stall_cnt +1 each cycle stall_fe|freeze; flush_cnt +1 each redirect acted upon; both saturate at 2^CNT_W−1. cnt_clr zeroes counters, wait counter unaffected, error flag cleared; cnt_clr wins over increment.

## Timing
- Forwarding, stall_fe, bubble_ex, flush, freeze, bubble_wb combinational on current inputs and state; no added latency.
- Load-use costs exactly 1 cycle; consumer takes load data from q5 next cycle.
- Counters, state, error flag update on rising clk.
- Reset: state RUN, wait count 0, stall_cnt=flush_cnt=0, mem_timeout_err=0; all control outputs 0 (fwd_sel=00 given idle inputs). Reset mid-wait abandons the access.
- mem_req_q3 & mem_ready same cycle: no freeze.

## Test plan
- rd_q4=5,wr_en_q4=1,result_q4=0xAA; rd_q5=5,wr_en_q5=1,result_q5=0xBB; rs_q3[0]=5 → fwd_op[0]=0xAA, fwd_sel[0]=01; drop wr_en_q4 → 0xBB, 10; rs=0 → op_q3.
- load_q3=1,rd_q3=7; rs_q2[1]=7,rs_used_q2[1]=1 → stall_fe=bubble_ex=1 one cycle, stall_cnt=1; rs_used_q2[1]=0 → no stall.
- mem_req_q3=1, mem_ready low 3 cycles then high → freeze high exactly 3 cycles, stall_cnt=3; MEM_TIMEOUT=2 → mem_timeout_err set and sticky until cnt_clr.
- redirect_q4 with FLUSH_DEPTH=2 → flush=011, flush_cnt=1; redirect during freeze → flush=000 until mem_ready.
- Redirect and load-use same cycle → flush only, stall_fe=0.
- CNT_W=4, 20 stall cycles → stall_cnt=15; rst_n low mid-MEM_WAIT → all outputs/counters 0, freeze drops asynchronously.
